// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the SHA-256 DMA job scheduler.
package dma_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ISSUE   = 4'd1,
        ST_RELEASE = 4'd2,
        ST_ABORT   = 4'd3,
        ST_DONE    = 4'd4,
        ST_FAULT   = 4'd5
    } sched_state_e;

    localparam logic [2:0] RES_OK       = 3'd0;
    localparam logic [2:0] RES_SLVERR   = 3'd1;
    localparam logic [2:0] RES_DECERR   = 3'd2;
    localparam logic [2:0] RES_INTERR   = 3'd3;
    localparam logic [2:0] RES_TIMEOUT  = 3'd4;
    localparam logic [2:0] RES_EMPTY    = 3'd5;
    localparam logic [2:0] RES_TOO_LONG = 3'd6;

    localparam int STS_OK_BIT     = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;

    localparam int JOB_W = 64;

endpackage

// File: rtl/dma_job_fifo.sv
// Show-ahead synchronous FIFO for queued hash jobs; flush drops every entry.
module dma_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];

    // A flush in the same cycle wins over a push: the push is discarded.
    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dma_job_scheduler.sv
// Feeds queued hash jobs to the SHA-256 DMA engine one at a time, matching
// each completion by status tag and reporting a result code per job.
module dma_job_scheduler
    import dma_sched_pkg::*;
#(
    parameter int          JOB_DEPTH   = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        job_push_i,
    input  logic [31:0] job_addr_i,
    input  logic [31:0] job_bitlen_i,
    output logic        job_full_o,
    output logic [4:0]  job_count_o,
    input  logic        flush_i,
    input  logic        fault_clear_i,
    input  logic        sha256_rdy_i,
    output logic        dma_enable_o,
    output logic [31:0] dma_base_addr_o,
    output logic [31:0] dma_bit_len_o,
    output logic        dma_start_o,
    input  logic [7:0]  dma_sts_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  result_o,
    output logic [15:0] done_count_o,
    output logic        overflow_o,
    output logic        fault_o,
    output logic [3:0]  dbg_state_o
);

    localparam int CW = $clog2(JOB_DEPTH) + 1;

    sched_state_e     r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_len;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic [2:0]       r_result;
    logic [2:0]       r_pend;
    logic [15:0]      r_done_cnt;
    logic [3:0]       r_exp_tag;
    logic             r_resync;
    logic [23:0]      r_timer;
    logic             r_phase;
    logic             r_to_fault;
    logic             r_overflow;

    logic [JOB_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_pop;
    logic             w_sts_hit;

    function automatic logic [2:0] map_status(input logic [7:0] sts);
        if (sts[STS_INTERR_BIT]) begin
            return RES_INTERR;
        end else if (sts[STS_DECERR_BIT]) begin
            return RES_DECERR;
        end else if (sts[STS_SLVERR_BIT]) begin
            return RES_SLVERR;
        end
        return RES_OK;
    endfunction

    dma_job_fifo #(
        .DEPTH (JOB_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (job_push_i),
        .wdata_i ({job_addr_i, job_bitlen_i}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // A new job is launched only while the hash core reports ready.
    assign w_pop = (r_state == ST_IDLE) && !w_empty && sha256_rdy_i;

    // A status counts once any completion bit is set and its tag is the one
    // expected, or unconditionally after a fault clear (tag resynchronisation).
    assign w_sts_hit = (|dma_sts_i[STS_OK_BIT:STS_INTERR_BIT]) &&
                       (r_resync || (dma_sts_i[3:0] == r_exp_tag));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_result   <= RES_OK;
            r_pend     <= RES_OK;
            r_done_cnt <= '0;
            r_exp_tag  <= 4'd1;
            r_resync   <= 1'b0;
            r_timer    <= '0;
            r_phase    <= 1'b0;
            r_to_fault <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_overflow <= r_overflow | (job_push_i & w_full);
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_addr <= w_head[63:32];
                        r_len  <= w_head[31:0];
                        if (w_head[31:0] == 32'd0) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_result   <= RES_EMPTY;
                            r_done_cnt <= r_done_cnt + 16'd1;
                            r_to_fault <= 1'b0;
                        end else if (w_head[31:26] != 6'd0) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_result   <= RES_TOO_LONG;
                            r_done_cnt <= r_done_cnt + 16'd1;
                            r_to_fault <= 1'b0;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_timer <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_timer <= r_timer + 24'd1;
                    if (w_sts_hit) begin
                        r_pend    <= map_status(dma_sts_i);
                        r_exp_tag <= dma_sts_i[3:0] + 4'd1;
                        r_resync  <= 1'b0;
                        r_start   <= 1'b0;
                        r_phase   <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end else if (r_timer == TIMEOUT_CYC - 24'd1) begin
                        r_start <= 1'b0;
                        r_phase <= 1'b0;
                        r_state <= ST_ABORT;
                    end
                end
                ST_RELEASE: begin
                    r_phase <= 1'b1;
                    if (r_phase) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_result   <= r_pend;
                        r_done_cnt <= r_done_cnt + 16'd1;
                        r_to_fault <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    r_phase <= 1'b1;
                    if (r_phase) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_result   <= RES_TIMEOUT;
                        r_done_cnt <= r_done_cnt + 16'd1;
                        r_to_fault <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_to_fault) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear_i) begin
                        r_state  <= ST_IDLE;
                        r_fault  <= 1'b0;
                        r_resync <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign dma_enable_o    = !(((r_state == ST_IDLE) && w_empty) ||
                               (r_state == ST_ABORT) || (r_state == ST_FAULT));
    assign dma_base_addr_o = r_addr;
    assign dma_bit_len_o   = r_len;
    assign dma_start_o     = r_start;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign result_o        = r_result;
    assign done_count_o    = r_done_cnt;
    assign overflow_o      = r_overflow;
    assign fault_o         = r_fault;
    assign dbg_state_o     = r_state;
    assign job_full_o      = w_full;
    assign job_count_o     = 5'(w_count);

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Bench for dma_job_scheduler: vector table, result scoreboard and engine model.
module tb_dma_job_scheduler;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        job_push_i = 1'b0;
    logic [31:0] job_addr_i = '0;
    logic [31:0] job_bitlen_i = '0;
    logic        job_full_o;
    logic [4:0]  job_count_o;
    logic        flush_i = 1'b0;
    logic        fault_clear_i = 1'b0;
    logic        sha256_rdy_i = 1'b1;
    logic        dma_enable_o;
    logic [31:0] dma_base_addr_o;
    logic [31:0] dma_bit_len_o;
    logic        dma_start_o;
    logic [7:0]  dma_sts_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  result_o;
    logic [15:0] done_count_o;
    logic        overflow_o;
    logic        fault_o;
    logic [3:0]  dbg_state_o;

    always #5 clk = ~clk;

    dma_job_scheduler #(
        .JOB_DEPTH   (4),
        .TIMEOUT_CYC (24'(TO))
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .job_push_i      (job_push_i),
        .job_addr_i      (job_addr_i),
        .job_bitlen_i    (job_bitlen_i),
        .job_full_o      (job_full_o),
        .job_count_o     (job_count_o),
        .flush_i         (flush_i),
        .fault_clear_i   (fault_clear_i),
        .sha256_rdy_i    (sha256_rdy_i),
        .dma_enable_o    (dma_enable_o),
        .dma_base_addr_o (dma_base_addr_o),
        .dma_bit_len_o   (dma_bit_len_o),
        .dma_start_o     (dma_start_o),
        .dma_sts_i       (dma_sts_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .done_count_o    (done_count_o),
        .overflow_o      (overflow_o),
        .fault_o         (fault_o),
        .dbg_state_o     (dbg_state_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [7:0]  sts;
        int          dly;
        logic [2:0]  res;
        bit          dma;
    } vec_t;

    vec_t       vecs[7];
    logic [2:0] sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_starts = 0;
    int         n_done = 0;
    int         mdl_done = 0;
    int         s0, d0, tcnt, lowcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] l);
        job_addr_i   = a;
        job_bitlen_i = l;
        job_push_i   = 1'b1;
        tick();
        job_push_i   = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (!dma_start_o && t < 300) begin
            tick();
            t++;
        end
        check("start_seen", dma_start_o, 1);
    endtask

    // Engine model: once start is seen, hold the old latched status for dly
    // cycles, then latch the new status (it stays latched afterwards).
    task automatic serve(input logic [7:0] sts, input int dly, input logic [31:0] a, input logic [31:0] l);
        wait_start();
        check("base_addr", dma_base_addr_o, a);
        check("bit_len", dma_bit_len_o, l);
        check("issue_en", dma_enable_o, 1);
        repeat (dly) tick();
        check("start_held", dma_start_o, 1);
        dma_sts_i = sts;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 300) begin
            tick();
            t++;
        end
        check("done_seen", n_done >= target, 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i     = 1'b0;
        dma_sts_i = '0;
        sb.delete();
        mdl_done = 0;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        logic       prev_start;
        logic [2:0] exp_r;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (dma_start_o && !prev_start) n_starts++;
                if (done_o) begin
                    n_done++;
                    check("sb_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_r = sb.pop_front();
                        mdl_done++;
                        check("result", result_o, exp_r);
                        check("done_count", done_count_o, mdl_done);
                    end
                end
            end
            prev_start = dma_start_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h1000_0000, 32'd512,        8'h81, 20, 3'd0, 1'b1};
        vecs[1] = '{32'h1000_0040, 32'd1024,       8'hC2, 5,  3'd1, 1'b1};
        vecs[2] = '{32'h1000_0080, 32'd256,        8'hA3, 3,  3'd2, 1'b1};
        vecs[3] = '{32'h1000_00C0, 32'd512,        8'h94, 7,  3'd3, 1'b1};
        vecs[4] = '{32'h1000_0100, 32'd0,          8'h00, 0,  3'd5, 1'b0};
        vecs[5] = '{32'h1000_0140, 32'h0400_0000,  8'h00, 0,  3'd6, 1'b0};
        vecs[6] = '{32'h1000_0180, 32'h03FF_FFFF,  8'hF5, 2,  3'd3, 1'b1};

        repeat (3) tick();
        check("rst_ctrl", {dma_enable_o, dma_start_o, busy_o, done_o, result_o, overflow_o,
                           fault_o, dbg_state_o, job_full_o, job_count_o}, 0);
        check("rst_dcount", done_count_o, 0);
        rst_i = 1'b0;
        tick();

        // Table of single jobs; tags advance 1..5 across the DMA entries.
        for (int i = 0; i < 7; i++) begin
            s0 = n_starts;
            d0 = n_done;
            sb.push_back(vecs[i].res);
            push_job(vecs[i].addr, vecs[i].len);
            if (vecs[i].dma) serve(vecs[i].sts, vecs[i].dly, vecs[i].addr, vecs[i].len);
            wait_done(d0 + 1);
            tick();
            tick();
            check("done_once", n_done, d0 + 1);
            check("start_cnt", n_starts - s0, vecs[i].dma ? 1 : 0);
            check("idle_en", dma_enable_o, 0);
        end

        // Overflow: five pushes into a depth-4 queue while the core is not ready.
        do_reset();
        sha256_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(3'd0);
            push_job(32'h2000_0000 + 32'(i * 64), 32'd512);
        end
        check("ovf_count", job_count_o, 4);
        check("ovf_full", job_full_o, 1);
        check("ovf_flag", overflow_o, 1);
        s0 = n_starts;
        d0 = n_done;
        sha256_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(8'h80 | 8'(i + 1), 4, 32'h2000_0000 + 32'(i * 64), 32'd512);
            wait_done(d0 + i + 1);
        end
        repeat (20) tick();
        check("ovf_starts", n_starts - s0, 4);
        check("ovf_drained", job_count_o, 0);

        // Timeout with the stale 0x84 latched, then fault and resync.
        sb.push_back(3'd4);
        push_job(32'h3000_0000, 32'd64);
        wait_start();
        tcnt = 0;
        while (!(busy_o && !dma_enable_o) && tcnt < 200) begin
            tick();
            tcnt++;
        end
        check("timeout_cycles", tcnt, TO);
        check("abort_start", dma_start_o, 0);
        lowcnt = 0;
        while (busy_o && !dma_enable_o && lowcnt < 5) begin
            tick();
            lowcnt++;
        end
        check("abort_len", lowcnt, 2);
        check("abort_done", done_o, 1);
        tick();
        check("fault_flag", fault_o, 1);
        check("fault_state", dbg_state_o, 5);
        check("fault_en", dma_enable_o, 0);
        s0 = n_starts;
        d0 = n_done;
        sb.push_back(3'd0);
        push_job(32'h3000_0040, 32'd128);
        repeat (3) tick();
        check("fault_keep_q", job_count_o, 1);
        check("fault_hold", fault_o, 1);
        dma_sts_i     = 8'h87;
        fault_clear_i = 1'b1;
        tick();
        fault_clear_i = 1'b0;
        wait_done(d0 + 1);
        check("resync_start", n_starts - s0, 1);
        check("fault_cleared", fault_o, 0);
        sb.push_back(3'd0);
        push_job(32'h3000_0080, 32'd256);
        serve(8'h88, 3, 32'h3000_0080, 32'd256);
        wait_done(d0 + 2);

        // Reset while a job is in flight and another is queued.
        push_job(32'h4000_0000, 32'd512);
        wait_start();
        push_job(32'h4000_0040, 32'd512);
        tick();
        rst_i = 1'b1;
        tick();
        check("mid_rst_ctrl", {dma_enable_o, dma_start_o, busy_o, done_o, result_o, overflow_o,
                               fault_o, dbg_state_o, job_full_o, job_count_o}, 0);
        check("mid_rst_addr", dma_base_addr_o, 0);
        check("mid_rst_len", dma_bit_len_o, 0);
        check("mid_rst_dcount", done_count_o, 0);
        rst_i     = 1'b0;
        dma_sts_i = '0;
        sb.delete();
        mdl_done = 0;

        // Flush together with a push discards both.
        sha256_rdy_i = 1'b0;
        push_job(32'h5000_0000, 32'd512);
        push_job(32'h5000_0040, 32'd512);
        check("pre_flush_cnt", job_count_o, 2);
        flush_i = 1'b1;
        push_job(32'h5000_0080, 32'd512);
        flush_i = 1'b0;
        check("flush_cnt", job_count_o, 0);
        s0 = n_starts;
        sha256_rdy_i = 1'b1;
        repeat (10) tick();
        check("flush_nostart", n_starts - s0, 0);

        // Push and pop in the same cycle keep the count unchanged.
        sha256_rdy_i = 1'b0;
        sb.push_back(3'd0);
        push_job(32'h6000_0000, 32'd512);
        check("pp_pre", job_count_o, 1);
        sha256_rdy_i = 1'b1;
        sb.push_back(3'd0);
        push_job(32'h6000_0040, 32'd1024);
        check("pp_cnt", job_count_o, 1);
        d0 = n_done;
        serve(8'h81, 2, 32'h6000_0000, 32'd512);
        wait_done(d0 + 1);
        serve(8'h82, 2, 32'h6000_0040, 32'd1024);
        wait_done(d0 + 2);
        repeat (3) tick();
        check("final_dcount", done_count_o, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_job_scheduler.md
Name: dma_job_scheduler

Overview:
- Sequences the SHA-256 DMA engine from a small queue of hash jobs, each a base address plus a bit length, written by the register bank.
- Per job: drives the engine's enable, base address, bit length and start inputs, then waits for the matching status tag.
- Maps the engine status to a result code and signals completion or timeout.
- Sits between the register bank and the DMA engine, and gates each start on sha256 ready.

Parameters:
- JOB_DEPTH, 4: job FIFO depth; power of two, 2..16.
- TIMEOUT_CYC, 24'd10_000_000: maximum cycles from the start assertion to a matching status.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: reset, synchronous, active-high.
- job_push_i, in, 1: enqueue a job (single-cycle strobe).
- job_addr_i, in, 32: job base byte address.
- job_bitlen_i, in, 32: job message length in bits.
- job_full_o, out, 1: FIFO full.
- job_count_o, out, 5: jobs queued; excludes the job in flight.
- flush_i, in, 1: drop all queued jobs; the in-flight job is not affected.
- fault_clear_i, in, 1: leave FAULT and resynchronise the tag.
- sha256_rdy_i, in, 1: hash core ready.
- dma_enable_o, out, 1: engine enable.
- dma_base_addr_o, out, 32: engine base address.
- dma_bit_len_o, out, 32: engine bit length.
- dma_start_o, out, 1: engine start (level).
- dma_sts_i, in, 8: engine latched status; [7] ok, [6] slverr, [5] decerr, [4] interr, [3:0] tag.
- busy_o, out, 1: job in flight.
- done_o, out, 1: one-cycle pulse per finished job.
- result_o, out, 3: code of the last finished job.
- done_count_o, out, 16: finished jobs; wraps.
- overflow_o, out, 1: sticky; a push was made while full. Cleared by rst_i only.
- fault_o, out, 1: in FAULT.
- dbg_state_o, out, 4: FSM state encoding.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs 0; result_o = 0.
  - FIFO emptied; FSM to IDLE; expected tag = 1; resync flag = 0.
  - rst_i is derived from the same source as the engine reset, so the tag counters start aligned.
- FIFO:
  - A push while full is dropped and sets overflow_o.
  - push and pop in the same cycle: count unchanged.
  - flush_i beats a simultaneous push; both are discarded.
- dma_enable_o = 1 in every state except IDLE-empty, ABORT and FAULT.
- IDLE: when the FIFO is non-empty, pop one job into the held address and length registers.
  - bitlen == 0: finish with result 5; no DMA.
  - bitlen[31:26] != 0: finish with result 6; no DMA.
  - Otherwise go to ISSUE.
- ISSUE:
  - dma_start_o = 1 and the addr/len outputs are held; the timeout counter runs.
  - Exit when dma_sts_i[7:4] != 0 and dma_sts_i[3:0] == expected tag, or when the resync flag is set (any tag accepted). Then:
    - capture the result and set expected tag = sts tag + 1 (mod 16);
    - clear the resync flag;
    - go to RELEASE.
  - A stale status from the previous job has the wrong tag and is ignored.
  - sha256_rdy_i low only delays command acceptance inside the engine; the timer keeps counting.
- RELEASE: dma_start_o = 0 for 2 cycles so the engine clears its running flag, then go to DONE.
- DONE (1 cycle):
  - done_o = 1; result_o updated; done_count_o += 1.
  - Next state is IDLE; a queued job is popped the following cycle, giving at least 4 cycles between starts.
- Timeout: the counter reaches TIMEOUT_CYC - 1 in ISSUE. Then:
  - go to ABORT: dma_enable_o = 0 and dma_start_o = 0 for 2 cycles;
  - go to DONE with result 4;
  - then go to FAULT.
- FAULT:
  - fault_o = 1; no pops; the queue is kept.
  - fault_clear_i sets the resync flag and returns to IDLE.
- Result mapping, highest priority first: interr → 3, decerr → 2, slverr → 1, ok → 0.
- Result codes: 0 ok, 1 slverr, 2 decerr, 3 interr, 4 timeout, 5 empty, 6 too long.
- busy_o = 1 in ISSUE, RELEASE and ABORT.
- fault_clear_i outside FAULT is ignored.

Decomposition:
- dma_sched_pkg holds:
  - the state enum (IDLE, ISSUE, RELEASE, ABORT, DONE, FAULT);
  - the result code localparams;
  - the status bit index constants.
- One sub-module, dma_job_fifo: synchronous FIFO, parameterised depth and width 64, with flush.

Test Plan:
- Push one job (addr 0x1000_0000, bitlen 512); the model returns sts 0x81 after 20 cycles → start high until then, done_o once, result 0, done_count 1, next expected tag 2.
- Push 5 jobs with JOB_DEPTH = 4 → overflow_o = 1, job_count 4, the 5th job never issued; tags 1..4 complete in order.
- The model presents a stale 0x81 during the second job, then 0xC2 → the stale status is ignored; result 1 (slverr) on 0xC2.
- bitlen 0, then bitlen 0x0400_0000 → results 5, then 6, with no dma_start_o pulse.
- TIMEOUT_CYC = 100 and no status → abort with enable low for 2 cycles, result 4, fault_o = 1. Then fault_clear_i with status 0x87 → accepted via resync, result 0, next expected tag 8.
- rst_i asserted mid-ISSUE → next cycle all outputs 0 and FIFO empty; flush_i together with push → count 0.
